// File: rtl/ripple_adder_reg_if.sv
// Operand/result bundle for ripple_adder_reg: the master drives the operands and the adder returns
// the registered sum and carry-out.
interface ripple_adder_reg_if #(
    parameter int unsigned N = 16
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] sum;
    logic         co;

    modport master (output a, output b, output cin, input sum, input co);
    modport slave  (input a, input b, input cin, output sum, output co);
endinterface

// File: rtl/ripple_adder_reg.sv
// N-bit ripple-carry adder built from a chain of full-adder cells.
// {co, sum} is captured in an output register; rst_n clears it asynchronously.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module ripple_adder_reg #(
    parameter int unsigned N = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    ripple_adder_reg_if.slave  bus
);
    logic [N:0]   w_c;
    logic [N-1:0] w_s;
    logic [N-1:0] r_sum;
    logic         r_co;

    assign w_c[0] = bus.cin;

    // Strict ripple: each cell takes its carry-in from the previous cell's carry-out.
    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder_cell u_fa (
            .i_a (bus.a[i]),
            .i_b (bus.b[i]),
            .i_c (w_c[i]),
            .o_s (w_s[i]),
            .o_c (w_c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_co  <= 1'b0;
        end else begin
            r_sum <= w_s;
            r_co  <= w_c[N];
        end
    end

    assign bus.sum = r_sum;
    assign bus.co  = r_co;
endmodule

// File: tb/tb_ripple_adder_reg.sv
// Directed and random checks of ripple_adder_reg at N = 16 and N = 1.
module tb_ripple_adder_reg;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ripple_adder_reg_if #(.N(16)) bus16 ();
    ripple_adder_reg_if #(.N(1))  bus1 ();

    ripple_adder_reg #(.N(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
    ripple_adder_reg #(.N(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic test_reset();
        rst_n = 1'b0;
        bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 1'b0;
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_0000) begin
            n_err++;
            $display("FAIL reset16_hold got co=%b sum=%h exp co=0 sum=0000", bus16.co, bus16.sum);
        end
        n_cmp++;
        if ({bus1.co, bus1.sum} !== 2'b00) begin
            n_err++;
            $display("FAIL reset1_hold got %b exp 00", {bus1.co, bus1.sum});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_2345) begin
            n_err++;
            $display("FAIL reset16_release got co=%b sum=%h exp co=0 sum=2345", bus16.co, bus16.sum);
        end
        n_cmp++;
        if ({bus1.co, bus1.sum} !== 2'b11) begin
            n_err++;
            $display("FAIL reset1_release got %b exp 11", {bus1.co, bus1.sum});
        end
    endtask

    task automatic test_directed();
        bus16.a = 16'h0000; bus16.b = 16'hFFFF; bus16.cin = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_FFFF) begin
            n_err++;
            $display("FAIL zero_plus_ones got co=%b sum=%h exp co=0 sum=ffff", bus16.co, bus16.sum);
        end
        bus16.a = 16'hFFFF; bus16.b = 16'h0000; bus16.cin = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h1_0000) begin
            n_err++;
            $display("FAIL full_ripple got co=%b sum=%h exp co=1 sum=0000", bus16.co, bus16.sum);
        end
        bus1.a = 1'b1; bus1.b = 1'b0; bus1.cin = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus1.co, bus1.sum} !== 2'b10) begin
            n_err++;
            $display("FAIL n1_ripple got %b exp 10", {bus1.co, bus1.sum});
        end
    endtask

    task automatic test_back_to_back();
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h1_FFFF) begin
            n_err++;
            $display("FAIL b2b_max got co=%b sum=%h exp co=1 sum=ffff", bus16.co, bus16.sum);
        end
        bus16.a = 16'h1234; bus16.b = 16'h4321; bus16.cin = 1'b0;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h1_FFFF) begin
            n_err++;
            $display("FAIL b2b_no_comb_path got co=%b sum=%h exp co=1 sum=ffff", bus16.co, bus16.sum);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_5555) begin
            n_err++;
            $display("FAIL b2b_second got co=%b sum=%h exp co=0 sum=5555", bus16.co, bus16.sum);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_0000) begin
            n_err++;
            $display("FAIL async_clear got co=%b sum=%h exp co=0 sum=0000", bus16.co, bus16.sum);
        end
        bus16.a = 16'hAAAA; bus16.b = 16'h5555; bus16.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h0_0000) begin
            n_err++;
            $display("FAIL async_hold got co=%b sum=%h exp co=0 sum=0000", bus16.co, bus16.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus16.co, bus16.sum} !== 17'h1_0000) begin
            n_err++;
            $display("FAIL async_release got co=%b sum=%h exp co=1 sum=0000", bus16.co, bus16.sum);
        end
    endtask

    task automatic test_random();
        logic [16:0] exp16;
        logic [1:0]  exp1;
        for (int i = 0; i < 1000; i++) begin
            bus16.a = 16'($urandom); bus16.b = 16'($urandom); bus16.cin = 1'($urandom);
            bus1.a = 1'($urandom); bus1.b = 1'($urandom); bus1.cin = 1'($urandom);
            exp16 = {1'b0, bus16.a} + {1'b0, bus16.b} + 17'(bus16.cin);
            exp1  = 2'(bus1.a) + 2'(bus1.b) + 2'(bus1.cin);
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus16.co, bus16.sum} !== exp16) begin
                n_err++;
                $display("FAIL rand16[%0d] got %h exp %h", i, {bus16.co, bus16.sum}, exp16);
            end
            n_cmp++;
            if ({bus1.co, bus1.sum} !== exp1) begin
                n_err++;
                $display("FAIL rand1[%0d] got %b exp %b", i, {bus1.co, bus1.sum}, exp1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
